// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Main control FSM for the multi-cycle RV32I core. Fetches into an internal
//   instruction register, then sequences FETCH/DECODE/EXEC/MEM/WB and drives
//   the ALU, register-file, PC and memory strobes. Illegal instructions park
//   the FSM in TRAP until reset. Counts retired instructions.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   instr               imem read data, captured when imem_req && imem_ready
//   imem_ready          imem accepts/returns the fetch this cycle
//   dmem_ready          dmem completes the access this cycle
//   branch_taken        ALU compare result, valid in EXEC
//   imem_req            fetch request
//   dmem_req, dmem_we   data access request, 1 = store
//   alu_op              00 add, 01 branch cmp, 10 R-type, 11 I-type
//   alu_ctrl            {m_ext, funct7[5], funct3} while alu_op is 10/11
//   reg_we, pc_we       register-file write / PC update strobes
//   pc_sel              00 pc+4, 01 pc+imm, 10 rs1+imm
//   trap                illegal instruction seen (held until reset)
//   state               current FSM state, for debug
//   instret             retired-instruction count, wraps

module multicycle_controller #(
  parameter int unsigned ENABLE_M  = 0,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 branch_taken,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [1:0]           alu_op,
  output logic [4:0]           alu_ctrl,
  output logic                 reg_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 trap,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  state_t                 state_q, state_d;
  logic [31:0]            ir_q, ir_d;
  logic [CNT_WIDTH-1:0]   instret_q, instret_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       m_allowed;
  logic       m_ext;
  logic       illegal;
  logic       ir_unused;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign funct7    = ir_q[31:25];
  assign m_allowed = (ENABLE_M != 0);
  assign m_ext     = (opcode == OPC_OP) && (funct7 == F7_MULD);

  // Register specifiers and immediates are consumed by the datapath, not here.
  assign ir_unused = ^{ir_q[24:15], ir_q[11:7]};

  always_comb begin
    illegal = 1'b0;
    if (ir_q[1:0] != 2'b11) illegal = 1'b1;
    case (opcode)
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: ;
      OPC_OP: begin
        if (!((funct7 == F7_BASE) ||
              ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))) ||
              ((funct7 == F7_MULD) && m_allowed)))
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only the shifts carry a funct7; SRAI alone may use the alternate form.
        if (funct3 == 3'b001 && funct7 != F7_BASE) illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    alu_op    = 2'b00;
    alu_ctrl  = '0;
    reg_we    = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'b00;
    trap      = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = illegal ? S_TRAP : S_EXEC;
      end

      S_EXEC: begin
        case (opcode)
          OPC_OP:     alu_op = 2'b10;
          OPC_OP_IMM: alu_op = 2'b11;
          OPC_BRANCH: alu_op = 2'b01;
          default:    alu_op = 2'b00;
        endcase
        if (alu_op[1]) alu_ctrl = {m_ext, funct7[5], funct3};

        if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
          state_d = S_MEM;
        end else if (opcode == OPC_BRANCH) begin
          pc_we     = 1'b1;
          pc_sel    = branch_taken ? 2'b01 : 2'b00;
          instret_d = instret_q + CNT_WIDTH'(1);
          state_d   = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OPC_STORE);
        if (dmem_ready) begin
          if (opcode == OPC_STORE) begin
            pc_we     = 1'b1;
            instret_d = instret_q + CNT_WIDTH'(1);
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        if (opcode == OPC_JAL)       pc_sel = 2'b01;
        else if (opcode == OPC_JALR) pc_sel = 2'b10;
        instret_d = instret_q + CNT_WIDTH'(1);
        state_d   = S_FETCH;
      end

      S_TRAP: begin
        trap = 1'b1;
      end

      default: state_d = S_FETCH;
    endcase

    // Reset must kill strobes immediately, not at the next edge, so an
    // in-flight memory access is abandoned the moment reset rises.
    if (reset) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      alu_op   = 2'b00;
      alu_ctrl = '0;
      reg_we   = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 2'b00;
      trap     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule
